gcf_seq_engine: RTL and testbench

//  Multi-cycle, handshaked greatest-common-factor engine using Euclid's algorithm by repeated subtraction.
//  - Serves as the clocked responder to the directed benches that exercise the combinational gcf.
//  - Accepts one operand pair, iterates one subtraction per clock, then returns the result.
//  - Intended drop-in wherever a single-cycle gcf would not close timing at large N.

---
 rtl/gcf_seq_engine.sv | 112 +++++++++++
 tb/tb_gcf_seq_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gcf_seq_engine.sv
// gcf_seq_engine: handshaked greatest-common-factor engine.
// Euclid's algorithm by repeated subtraction, one subtraction per clock.
// Handshake: in_valid/in_ready accepts an operand pair, out_valid/out_ready
// returns the result. One pair is in flight at a time.
// Optional feature macro: GCF_CYCLE_COUNT_EN adds the 'cycles' output, a
// saturating count of CALC cycles spent on the most recent pair.
module gcf_seq_engine #(
    parameter int N     = 16,
    parameter int CNT_W = N + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     res
`ifdef GCF_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         accept;
    logic         finish;

    // Elaboration-time sanity check on the parameters.
    if (N < 2 || CNT_W < 1) begin : g_bad_params
        $error("gcf_seq_engine: N must be >= 2 and CNT_W >= 1");
    end

    // A pair is taken only while idle; the step terminates when either
    // working value reaches zero or the two meet.
    always_comb begin
        accept = (state == IDLE) && in_valid && in_ready;
        finish = (x == '0) || (y == '0) || (x == y);
    end

    // Control FSM with registered handshake outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            res       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x        <= a;
                        y        <= b;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (finish) begin
                        // One operand is zero or both are equal: x|y is the answer.
                        res       <= x | y;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (x > y) begin
                        x <= x - y;
                    end else begin
                        y <= y - x;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef GCF_CYCLE_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // CALC cycle counter: cleared on accept, saturating, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= '0;
        end else if (accept) begin
            cycles <= '0;
        end else if (state == CALC && cycles != '1) begin
            cycles <= cycles + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_gcf_seq_engine.sv
// Directed bench for gcf_seq_engine (N=16). Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_gcf_seq_engine;

    localparam int N     = 16;
    localparam int CNT_W = N + 1;
    localparam int LIMIT = 200;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     a = '0;
    logic [N-1:0]     b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     res;
`ifdef GCF_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycles;
`endif

    int passed = 0;
    int total  = 0;

    gcf_seq_engine #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
`ifdef GCF_CYCLE_COUNT_EN
        ,
        .cycles    (cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid; returns number of edges waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < LIMIT) begin
            step();
            n++;
        end
    endtask

    // Full transaction: accept, compute, check latency/result, consume.
    task automatic run_pair(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                            input logic [N-1:0] exp_res, input int exp_k);
        int n;
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(n);
        chk({tag, "_latency"}, 32'(n), 32'(exp_k));
        chk({tag, "_res"}, 32'(res), 32'(exp_res));
`ifdef GCF_CYCLE_COUNT_EN
        chk({tag, "_cycles"}, 32'(cycles), 32'(exp_k));
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_vdrop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        logic [N-1:0] exp_q[3];
        int           k_q[3];

        // Reset state
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Main function and boundary cases
        run_pair("p24_36", 16'd24, 16'd36, 16'd12, 3);
        run_pair("p18_48", 16'd18, 16'd48, 16'd6, 5);
        run_pair("p7_3", 16'd7, 16'd3, 16'd1, 5);
        run_pair("p101_303", 16'd101, 16'd303, 16'd101, 3);
        run_pair("p0_5", 16'd0, 16'd5, 16'd5, 1);
        run_pair("p9_0", 16'd9, 16'd0, 16'd9, 1);
        run_pair("p0_0", 16'd0, 16'd0, 16'd0, 1);
        run_pair("p77_77", 16'd77, 16'd77, 16'd77, 1);

        // Backpressure with ignored in_valid pulses during CALC/DONE
        a = 16'd18;
        b = 16'd48;
        in_valid = 1'b1;
        step();
        a = 16'd9;
        b = 16'd6;
        step();
        chk("bp_calc_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        wait_valid(n);
        chk("bp_latency_ok", 32'(n < LIMIT), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_res", 32'(res), 32'd6);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release", 32'(out_valid), 32'd0);
        step();
        chk("bp_no_accept", 32'(in_ready), 32'd1);

        // Reset mid-CALC of the worst-case pair
        a = 16'd65535;
        b = 16'd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_res", 32'(res), 32'd0);
`ifdef GCF_CYCLE_COUNT_EN
        chk("mid_rst_cycles", 32'(cycles), 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        run_pair("post_rst", 16'd24, 16'd36, 16'd12, 3);

        // Back-to-back: in_valid held high, out_ready held high
        exp_q[0] = 16'd12; k_q[0] = 3;
        exp_q[1] = 16'd1;  k_q[1] = 5;
        exp_q[2] = 16'd5;  k_q[2] = 1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'd24;
        b = 16'd36;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!in_ready && n < LIMIT) begin
                step();
                n++;
            end
            chk("b2b_ready_wait", 32'(n < LIMIT), 32'd1);
            step();
            chk("b2b_busy", 32'(in_ready), 32'd0);
            // Present the next pair right away; it must wait for IDLE.
            if (i == 0) begin
                a = 16'd7;
                b = 16'd3;
            end else begin
                a = 16'd0;
                b = 16'd5;
            end
            wait_valid(n);
            chk("b2b_latency", 32'(n), 32'(k_q[i]));
            chk("b2b_res", 32'(res), 32'(exp_q[i]));
            step();
            chk("b2b_done_1cyc", 32'(out_valid), 32'd0);
            if (i == 2) in_valid = 1'b0;
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) n++;
        end
        chk("b2b_no_dup", 32'(n), 32'd0);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
